// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword load-store sequencer in front of a 128x8 sync-read memory
module load_store_unit #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic              reqWord,
    input  logic              reqSigned,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [15:0]       reqWData,
    output logic              respValid,
    input  logic              respReady,
    output logic [15:0]       respRData,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] lineNumber,
    output logic [7:0]        memIn,
    input  logic [7:0]        memOut
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BEAT0 = 3'd1;
    localparam logic [2:0] S_BEAT1 = 3'd2;
    localparam logic [2:0] S_LAST  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]        r_state;
    logic              r_write;
    logic              r_word;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_rdata;

    logic              w_beat;
    logic [ADDR_W-1:0] w_addr_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_write  <= 1'b0;
            r_word   <= 1'b0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 16'h0000;
            r_rdata  <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (reqValid) begin
                        r_write  <= reqWrite;
                        r_word   <= reqWord;
                        r_signed <= reqSigned;
                        r_addr   <= reqAddr;
                        r_wdata  <= reqWData;
                        r_rdata  <= 16'h0000;
                        r_state  <= S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (r_word)       r_state <= S_BEAT1;
                    else if (r_write) r_state <= S_RESP;
                    else              r_state <= S_LAST;
                end
                S_BEAT1: begin
                    // memOut here carries the low byte requested in BEAT0
                    if (!r_write) r_rdata[7:0] <= memOut;
                    r_state <= r_write ? S_RESP : S_LAST;
                end
                S_LAST: begin
                    if (r_word) r_rdata[15:8] <= memOut;
                    else        r_rdata <= {(r_signed ? {8{memOut[7]}} : 8'h00), memOut};
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (respReady) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_beat    = (r_state == S_BEAT0) || (r_state == S_BEAT1);
    assign w_addr_hi = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    assign reqReady  = (r_state == S_IDLE);
    assign respValid = (r_state == S_RESP);
    assign respRData = r_rdata;
    assign memWrite  = w_beat && r_write;
    assign memRead   = w_beat && !r_write;

    always_comb begin
        lineNumber = '0;
        memIn      = 8'h00;
        if (r_state == S_BEAT0) begin
            lineNumber = r_addr;
            memIn      = r_wdata[7:0];
        end else if (r_state == S_BEAT1) begin
            lineNumber = w_addr_hi;
            memIn      = r_wdata[15:8];
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a dataMemory stand-in
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid, reqReady, reqWrite, reqWord, reqSigned;
    logic [6:0]  reqAddr;
    logic [15:0] reqWData;
    logic        respValid, respReady;
    logic [15:0] respRData;
    logic        memRead, memWrite;
    logic [6:0]  lineNumber;
    logic [7:0]  memIn;
    logic [7:0]  memOut;

    int vectors = 0;
    int miscompares = 0;
    int wr_cycles = 0;

    load_store_unit #(.ADDR_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqWord(reqWord),
        .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWData(reqWData),
        .respValid(respValid), .respReady(respReady), .respRData(respRData),
        .memRead(memRead), .memWrite(memWrite), .lineNumber(lineNumber),
        .memIn(memIn), .memOut(memOut)
    );

    always #5 clk = ~clk;

    // Physical memory driven by the DUT: synchronous write, registered 1-cycle read.
    logic [7:0] mem [0:127];
    always @(posedge clk) begin
        if (memWrite) mem[lineNumber] <= memIn;
        if (memRead)  memOut <= mem[lineNumber];
    end

    // Transaction-level reference: a request occupies a fixed schedule of beats,
    // then a response slot that lasts until the consumer accepts it.
    logic [7:0]  ref_mem [0:127];
    logic        m_active;
    int          m_c, m_lat, m_beats;
    logic        m_w;
    logic [6:0]  m_addr;
    logic [15:0] m_d, m_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_c      <= 0;
        end else if (m_active) begin
            if (m_w && m_c < m_beats)
                ref_mem[7'(m_addr + 7'(m_c))] <= (m_c == 0) ? m_d[7:0] : m_d[15:8];
            if (m_c >= m_lat - 1 && respReady) m_active <= 1'b0;
            else                               m_c <= m_c + 1;
        end else if (reqValid) begin
            m_active <= 1'b1;
            m_c      <= 0;
            m_w      <= reqWrite;
            m_addr   <= reqAddr;
            m_d      <= reqWData;
            m_beats  <= reqWord ? 2 : 1;
            m_lat    <= reqWrite ? (reqWord ? 3 : 2) : (reqWord ? 4 : 3);
            if (reqWrite)     m_rdata <= 16'h0000;
            else if (reqWord) m_rdata <= {ref_mem[7'(reqAddr + 7'd1)], ref_mem[reqAddr]};
            else if (reqSigned) m_rdata <= {{8{ref_mem[reqAddr][7]}}, ref_mem[reqAddr]};
            else              m_rdata <= {8'h00, ref_mem[reqAddr]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic       e_rd, e_wr, e_rv;
    logic [6:0] e_line;
    logic [7:0] e_in;
    always @(negedge clk) begin
        if (rst_n) begin
            e_rd = 1'b0; e_wr = 1'b0; e_line = 7'd0; e_in = 8'h00;
            if (m_active && m_c < m_beats) begin
                e_rd   = !m_w;
                e_wr   = m_w;
                e_line = 7'(m_addr + 7'(m_c));
                e_in   = (m_c == 0) ? m_d[7:0] : m_d[15:8];
            end
            e_rv = m_active && (m_c >= m_lat - 1);
            chk("reqReady", {31'd0, reqReady}, {31'd0, !m_active});
            chk("respValid", {31'd0, respValid}, {31'd0, e_rv});
            chk("memRead", {31'd0, memRead}, {31'd0, e_rd});
            chk("memWrite", {31'd0, memWrite}, {31'd0, e_wr});
            chk("lineNumber", {25'd0, lineNumber}, {25'd0, e_line});
            chk("memIn", {24'd0, memIn}, {24'd0, e_in});
            chk("rd_wr_exclusive", {31'd0, memRead && memWrite}, 32'd0);
            if (e_rv) chk("respRData", {16'd0, respRData}, {16'd0, m_rdata});
            if (memWrite) wr_cycles++;
        end
    end

    task automatic run_req(input logic w, input logic wd, input logic sg, input logic [6:0] a,
                           input logic [15:0] d, input int hold, input logic keep,
                           output int lat, output logic [15:0] rdata);
        int t;
        @(negedge clk); #1;
        reqValid = 1'b1; reqWrite = w; reqWord = wd; reqSigned = sg; reqAddr = a; reqWData = d;
        respReady = (hold == 0);
        t = 0;
        while (!reqReady && t < 20) begin @(negedge clk); #1; t++; end
        if (t == 20) chk("accept_timeout", 32'(t), 32'd0);
        @(posedge clk); #1;
        reqValid = keep;
        reqWData = ~d;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!respValid && lat < 20);
        rdata = respRData;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_valid", {31'd0, respValid}, 32'd1);
                chk("hold_ready", {31'd0, reqReady}, 32'd0);
                chk("hold_rdata", {16'd0, respRData}, {16'd0, rdata});
                @(negedge clk);
            end
            #1 respReady = 1'b1;
        end
        @(posedge clk); #1;
        respReady = keep;
    endtask

    int          lat;
    logic [15:0] rd;

    initial begin
        for (int i = 0; i < 128; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        memOut = 8'h00;
        rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqWord = 1'b0; reqSigned = 1'b0;
        reqAddr = 7'd0; reqWData = 16'h0000; respReady = 1'b0;
        #12;
        chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
        chk("rst_respValid", {31'd0, respValid}, 32'd0);
        chk("rst_respRData", {16'd0, respRData}, 32'd0);
        chk("rst_mem_ctl", {30'd0, memRead, memWrite}, 32'd0);
        chk("rst_line_in", {17'd0, lineNumber, memIn}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;

        // 1: byte store then unsigned byte load
        wr_cycles = 0;
        run_req(1, 0, 0, 7'd10, 16'h12A5, 0, 0, lat, rd);
        chk("t1_store_lat", 32'(lat), 32'd2);
        chk("t1_store_rdata", {16'd0, rd}, 32'd0);
        chk("t1_wr_cycles", 32'(wr_cycles), 32'd1);
        chk("t1_mem10", {24'd0, mem[10]}, 32'h000000A5);
        run_req(0, 0, 0, 7'd10, 16'h0000, 0, 0, lat, rd);
        chk("t1_load_lat", 32'(lat), 32'd3);
        chk("t1_load_rdata", {16'd0, rd}, 32'h000000A5);

        // 2: sign extension
        run_req(1, 0, 0, 7'd20, 16'h0080, 0, 0, lat, rd);
        run_req(0, 0, 1, 7'd20, 16'h0000, 0, 0, lat, rd);
        chk("t2_signed", {16'd0, rd}, 32'h0000FF80);
        run_req(0, 0, 0, 7'd20, 16'h0000, 0, 0, lat, rd);
        chk("t2_unsigned", {16'd0, rd}, 32'h00000080);

        // 3: word store/load wrapping at the top of memory
        run_req(1, 1, 0, 7'd127, 16'hBEEF, 0, 0, lat, rd);
        chk("t3_store_lat", 32'(lat), 32'd3);
        chk("t3_mem127", {24'd0, mem[127]}, 32'h000000EF);
        chk("t3_mem0", {24'd0, mem[0]}, 32'h000000BE);
        chk("t3_ref_mem0", {24'd0, ref_mem[0]}, 32'h000000BE);
        run_req(0, 1, 0, 7'd127, 16'h0000, 0, 0, lat, rd);
        chk("t3_load_lat", 32'(lat), 32'd4);
        chk("t3_load_rdata", {16'd0, rd}, 32'h0000BEEF);

        // 4: response back-pressure
        run_req(0, 1, 0, 7'd127, 16'h0000, 5, 0, lat, rd);
        chk("t4_rdata", {16'd0, rd}, 32'h0000BEEF);
        chk("t4_idle_after", {31'd0, reqReady}, 32'd1);

        // 5: reset during BEAT1 of a word store
        @(negedge clk); #1;
        reqValid = 1'b1; reqWrite = 1'b1; reqWord = 1'b1; reqSigned = 1'b0;
        reqAddr = 7'd50; reqWData = 16'h1234; respReady = 1'b0;
        @(posedge clk); #1 reqValid = 1'b0;
        @(posedge clk); #2;
        chk("t5_beat1_wr", {31'd0, memWrite}, 32'd1);
        chk("t5_beat1_line", {25'd0, lineNumber}, 32'd51);
        rst_n = 1'b0; #1;
        chk("t5_wr_drop", {31'd0, memWrite}, 32'd0);
        chk("t5_line_clr", {25'd0, lineNumber}, 32'd0);
        chk("t5_ready", {31'd0, reqReady}, 32'd1);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_resp", {31'd0, respValid}, 32'd0);
        chk("t5_mem50", {24'd0, mem[50]}, 32'h00000034);
        chk("t5_mem51", {24'd0, mem[51]}, 32'h00000000);

        // 6: back-to-back with reqValid held high
        run_req(1, 0, 0, 7'd30, 16'h005A, 0, 1, lat, rd);
        chk("t6_bs_lat", 32'(lat), 32'd2);
        run_req(1, 1, 0, 7'd31, 16'hC3D2, 0, 1, lat, rd);
        chk("t6_ws_lat", 32'(lat), 32'd3);
        run_req(0, 0, 0, 7'd30, 16'h0000, 0, 1, lat, rd);
        chk("t6_bl_lat", 32'(lat), 32'd3);
        chk("t6_bl_rdata", {16'd0, rd}, 32'h0000005A);
        run_req(0, 1, 0, 7'd31, 16'h0000, 0, 0, lat, rd);
        chk("t6_wl_lat", 32'(lat), 32'd4);
        chk("t6_wl_rdata", {16'd0, rd}, 32'h0000C3D2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
